// File: rtl/branch_target_predictor_if.sv
// Fetch lookup / execute update bus between the datapath and the branch target predictor.
interface branch_target_predictor_if;
    // Fetch-stage lookup
    logic [31:0] lu_pc;
    logic        lu_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    // Execute-stage training
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_jump;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] correct_pc;
    // Maintenance
    logic        inv_all;

    modport master (
        output lu_pc, upd_en, upd_pc, upd_jump, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target, inv_all,
        input  lu_hit, pred_taken, pred_target, mispredict, correct_pc
    );

    modport slave (
        input  lu_pc, upd_en, upd_pc, upd_jump, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target, inv_all,
        output lu_hit, pred_taken, pred_target, mispredict, correct_pc
    );
endinterface

// File: rtl/branch_target_predictor.sv
// Branch target buffer with 2-bit saturating direction counters.
// Combinational lookup at fetch, registered training from execute.
// Optional hit/mispredict statistics counters are enabled with `define BTB_STATS_EN.
module branch_target_predictor #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned TAG_W   = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    branch_target_predictor_if.slave bus
`ifdef BTB_STATS_EN
    ,
    output logic [CNT_W-1:0]        stat_hits,
    output logic [CNT_W-1:0]        stat_mispred
`endif
);
    localparam int unsigned IDX_W  = $clog2(ENTRIES);
    localparam int unsigned TAG_LO = IDX_W + 2;

    // Elaboration-time parameter sanity
    if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
        $error("ENTRIES must be a power of 2 and >= 2");
    end
    if (TAG_LO + TAG_W > 32) begin : g_bad_tag
        $error("IDX_W+2+TAG_W must not exceed 32");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $error("CNT_W must be at least 1");
    end

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [31:0]        target_d [ENTRIES];
    logic [1:0]         cnt_q    [ENTRIES];
    logic [1:0]         cnt_d    [ENTRIES];

    logic [IDX_W-1:0] lu_idx, upd_idx;
    logic [TAG_W-1:0] lu_tag, upd_tag;
    logic             lu_hit_w, upd_hit_w, mispredict_w;

    // Lookup: reads pre-update contents in the same cycle
    always_comb begin
        lu_idx          = bus.lu_pc[IDX_W+1:2];
        lu_tag          = bus.lu_pc[TAG_LO+TAG_W-1:TAG_LO];
        lu_hit_w        = valid_q[lu_idx] && (tag_q[lu_idx] == lu_tag);
        bus.lu_hit      = lu_hit_w;
        bus.pred_taken  = lu_hit_w && cnt_q[lu_idx][1];
        bus.pred_target = (lu_hit_w && cnt_q[lu_idx][1]) ? target_q[lu_idx]
                                                          : bus.lu_pc + 32'd4;
    end

    // Resolution check against the prediction carried down the pipe
    always_comb begin
        mispredict_w   = bus.upd_en &&
                         ((bus.upd_taken != bus.upd_pred_taken) ||
                          (bus.upd_taken && (bus.upd_target != bus.upd_pred_target)));
        bus.mispredict = mispredict_w;
        bus.correct_pc = bus.upd_taken ? bus.upd_target : bus.upd_pc + 32'd4;
    end

    // Next-state of the table: invalidate-all wins over training
    always_comb begin
        valid_d   = valid_q;
        tag_d     = tag_q;
        target_d  = target_q;
        cnt_d     = cnt_q;
        upd_idx   = bus.upd_pc[IDX_W+1:2];
        upd_tag   = bus.upd_pc[TAG_LO+TAG_W-1:TAG_LO];
        upd_hit_w = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        if (bus.inv_all) begin
            valid_d = '0;
        end else if (bus.upd_en) begin
            if (upd_hit_w) begin
                if (bus.upd_jump) begin
                    cnt_d[upd_idx] = 2'b11;
                end else if (bus.upd_taken) begin
                    if (cnt_q[upd_idx] != 2'b11) cnt_d[upd_idx] = cnt_q[upd_idx] + 2'd1;
                end else begin
                    if (cnt_q[upd_idx] != 2'b00) cnt_d[upd_idx] = cnt_q[upd_idx] - 2'd1;
                end
                if (bus.upd_taken) target_d[upd_idx] = bus.upd_target;
            end else if (bus.upd_taken) begin
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = bus.upd_target;
                cnt_d[upd_idx]    = bus.upd_jump ? 2'b11 : 2'b10;
            end
        end
    end

    // Valid bits and counters: reset drops any same-cycle training
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) cnt_q[i] <= 2'b01;
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    // Tags and targets carry no reset; they are qualified by valid
    always_ff @(posedge CLK) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

`ifdef BTB_STATS_EN
    logic [CNT_W-1:0] stat_hits_q, stat_hits_d;
    logic [CNT_W-1:0] stat_mispred_q, stat_mispred_d;

    // Saturating statistics; invalidate-all leaves them alone
    always_comb begin
        stat_hits_d    = stat_hits_q;
        stat_mispred_d = stat_mispred_q;
        if (lu_hit_w && (stat_hits_q != '1))        stat_hits_d    = stat_hits_q + CNT_W'(1);
        if (mispredict_w && (stat_mispred_q != '1)) stat_mispred_d = stat_mispred_q + CNT_W'(1);
    end

    // Statistics registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            stat_hits_q    <= '0;
            stat_mispred_q <= '0;
        end else begin
            stat_hits_q    <= stat_hits_d;
            stat_mispred_q <= stat_mispred_d;
        end
    end

    assign stat_hits    = stat_hits_q;
    assign stat_mispred = stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor: vector table plus reset/stats sequences.
module tb_branch_target_predictor;
    logic CLK = 1'b0;
    logic RST;

    branch_target_predictor_if bus();

`ifdef BTB_STATS_EN
    logic [15:0] stat_hits, stat_mispred;
`endif

    branch_target_predictor #(.ENTRIES(16), .TAG_W(8), .CNT_W(16)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .bus          (bus.slave)
`ifdef BTB_STATS_EN
        ,
        .stat_hits    (stat_hits),
        .stat_mispred (stat_mispred)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] lu_pc;
        logic        upd_en;
        logic        jump;
        logic        taken;
        logic [31:0] upd_pc;
        logic [31:0] tgt;
        logic        ptk;
        logic [31:0] ptgt;
        logic        inv;
        logic        e_hit;
        logic        e_pt;
        logic [31:0] e_tgt;
        logic        e_mp;
        logic [31:0] e_cp;
    } vec_t;

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    function automatic vec_t mk(
        input logic [31:0] lu_pc, input logic upd_en, input logic jump, input logic taken,
        input logic [31:0] upd_pc, input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
        input logic inv, input logic e_hit, input logic e_pt, input logic [31:0] e_tgt,
        input logic e_mp, input logic [31:0] e_cp);
        vec_t v;
        v.lu_pc = lu_pc; v.upd_en = upd_en; v.jump = jump; v.taken = taken;
        v.upd_pc = upd_pc; v.tgt = tgt; v.ptk = ptk; v.ptgt = ptgt; v.inv = inv;
        v.e_hit = e_hit; v.e_pt = e_pt; v.e_tgt = e_tgt; v.e_mp = e_mp; v.e_cp = e_cp;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.lu_pc           = v.lu_pc;
        bus.upd_en          = v.upd_en;
        bus.upd_jump        = v.jump;
        bus.upd_taken       = v.taken;
        bus.upd_pc          = v.upd_pc;
        bus.upd_target      = v.tgt;
        bus.upd_pred_taken  = v.ptk;
        bus.upd_pred_target = v.ptgt;
        bus.inv_all         = v.inv;
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        chk({tag, " lu_hit"},      32'(bus.lu_hit),     32'(v.e_hit));
        chk({tag, " pred_taken"},  32'(bus.pred_taken), 32'(v.e_pt));
        chk({tag, " pred_target"}, bus.pred_target,     v.e_tgt);
        chk({tag, " mispredict"},  32'(bus.mispredict), 32'(v.e_mp));
        chk({tag, " correct_pc"},  bus.correct_pc,      v.e_cp);
    endtask

    // Idle bus with only a lookup
    function automatic vec_t idle(input logic [31:0] pc, input logic hit, input logic pt,
                                  input logic [31:0] tgt);
        return mk(pc, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, hit, pt, tgt, 0, 32'h4);
    endfunction

    vec_t vecs[22];
    vec_t v;

    initial begin
        // Main training sequence; each row is one cycle, outputs checked before its edge
        vecs[0]  = idle(32'h40, 0, 0, 32'h44);
        vecs[1]  = mk(32'h40, 1, 0, 1, 32'h40, 32'h100, 0, 32'h44,  0, 0, 0, 32'h44,  1, 32'h100);
        vecs[2]  = mk(32'h40, 1, 0, 0, 32'h40, 32'h100, 1, 32'h100, 0, 1, 1, 32'h100, 1, 32'h44);
        vecs[3]  = mk(32'h40, 1, 0, 0, 32'h40, 32'h100, 1, 32'h100, 0, 1, 0, 32'h44,  1, 32'h44);
        vecs[4]  = mk(32'h40, 1, 0, 1, 32'h40, 32'h100, 0, 32'h44,  0, 1, 0, 32'h44,  1, 32'h100);
        vecs[5]  = mk(32'h40, 1, 0, 1, 32'h40, 32'h100, 0, 32'h44,  0, 1, 0, 32'h44,  1, 32'h100);
        vecs[6]  = idle(32'h40, 1, 1, 32'h100);
        vecs[7]  = mk(32'h40, 1, 0, 1, 32'h40, 32'h200, 1, 32'h100, 0, 1, 1, 32'h100, 1, 32'h200);
        vecs[8]  = mk(32'h40, 1, 0, 1, 32'h40, 32'h200, 1, 32'h200, 0, 1, 1, 32'h200, 0, 32'h200);
        vecs[9]  = mk(32'h440, 1, 0, 1, 32'h440, 32'h300, 0, 32'h444, 0, 0, 0, 32'h444, 1, 32'h300);
        vecs[10] = idle(32'h40, 0, 0, 32'h44);
        vecs[11] = idle(32'h440, 1, 1, 32'h300);
        vecs[12] = mk(32'h80, 1, 1, 1, 32'h80, 32'h500, 0, 32'h84,  0, 0, 0, 32'h84,  1, 32'h500);
        vecs[13] = idle(32'h80, 1, 1, 32'h500);
        vecs[14] = mk(32'h80, 1, 0, 0, 32'h80, 32'h500, 1, 32'h500, 0, 1, 1, 32'h500, 1, 32'h84);
        vecs[15] = idle(32'h80, 1, 1, 32'h500);
        vecs[16] = idle(32'hFFFFFFFC, 0, 0, 32'h0);
        vecs[17] = mk(32'h80, 1, 0, 1, 32'h48, 32'h600, 0, 32'h4C,  1, 1, 1, 32'h500, 1, 32'h600);
        vecs[18] = idle(32'h80, 0, 0, 32'h84);
        vecs[19] = idle(32'h48, 0, 0, 32'h4C);
        vecs[20] = mk(32'h48, 0, 0, 1, 32'h48, 32'h700, 0, 32'h4C,  0, 0, 0, 32'h4C,  0, 32'h700);
        vecs[21] = idle(32'h48, 0, 0, 32'h4C);

        RST = 1'b1;
        drive(idle(32'h0, 0, 0, 32'h4));
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(negedge CLK);
            check_vec($sformatf("v%0d", i), vecs[i]);
            @(posedge CLK);
            #1;
        end

        // Reset clears a trained entry and drops a same-cycle update
        drive(mk(32'h10, 1, 0, 1, 32'h10, 32'h800, 0, 32'h14, 0, 0, 0, 32'h14, 1, 32'h800));
        @(posedge CLK); #1;
        RST = 1'b1;
        drive(mk(32'h20, 1, 1, 1, 32'h20, 32'h900, 0, 32'h24, 0, 0, 0, 32'h24, 1, 32'h900));
        @(posedge CLK); #1;
        RST = 1'b0;
        v = idle(32'h10, 0, 0, 32'h14);
        drive(v);
        @(negedge CLK);
        check_vec("rst_clears", v);
        @(posedge CLK); #1;
        v = idle(32'h20, 0, 0, 32'h24);
        drive(v);
        @(negedge CLK);
        check_vec("rst_drops_upd", v);

`ifdef BTB_STATS_EN
        chk("stats_after_rst hits", 32'(stat_hits), 32'd0);
        chk("stats_after_rst mispred", 32'(stat_mispred), 32'd0);
        // One mispredicting allocate, three hits, one target-mismatch mispredict
        @(posedge CLK); #1;
        drive(mk(32'h10, 1, 0, 1, 32'h10, 32'h800, 0, 32'h14, 0, 0, 0, 32'h14, 1, 32'h800));
        @(posedge CLK); #1;
        drive(idle(32'h10, 1, 0, 32'h0));
        @(posedge CLK); #1;
        drive(mk(32'h10, 1, 0, 1, 32'h10, 32'h880, 1, 32'h800, 0, 0, 0, 32'h0, 1, 32'h880));
        @(posedge CLK); #1;
        drive(idle(32'h10, 1, 0, 32'h0));
        @(posedge CLK); #1;
        drive(idle(32'h30, 0, 0, 32'h34));
        @(negedge CLK);
        chk("stat_hits", 32'(stat_hits), 32'd3);
        chk("stat_mispred", 32'(stat_mispred), 32'd2);
        // inv_all must not clear statistics
        @(posedge CLK); #1;
        bus.inv_all = 1'b1;
        @(posedge CLK); #1;
        bus.inv_all = 1'b0;
        @(negedge CLK);
        chk("stat_hits_after_inv", 32'(stat_hits), 32'd3);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("stat_hits_rst", 32'(stat_hits), 32'd0);
        chk("stat_mispred_rst", 32'(stat_mispred), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
- Parametrised branch target buffer with 2-bit saturating direction counters for the fetch stage of the pipelined datapath.
- Replaces fixed PC+4 fetch with a predicted next PC.
- Looked up combinationally each fetch with the current PC.
- Trained from the execute stage with resolved branch/jump outcomes; reports mispredicts and the corrected PC so the datapath can flush IF/ID and ID/EX.

Parameters:
- ENTRIES, 16, number of BTB entries; power of 2, >=2.
- TAG_W, 8, stored tag bits taken from pc[IDX_W+2+TAG_W-1 : IDX_W+2], with IDX_W = log2(ENTRIES); IDX_W+2+TAG_W <= 32.
- CNT_W, 16, width of statistics counters (optional feature only).

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- lu_pc  in  32  fetch PC (word-aligned)
- lu_hit  out  1  valid entry with matching tag at lu_pc
- pred_taken  out  1  lu_hit && counter[1]
- pred_target  out  32  stored target if pred_taken, else lu_pc+4
- upd_en  in  1  execute-stage instruction is a resolved branch/jump; qualified by pipeline enable
- upd_pc  in  32  PC of the resolved instruction
- upd_jump  in  1  unconditional (J/JAL/JR)
- upd_taken  in  1  actual direction (1 when upd_jump)
- upd_target  in  32  actual taken target
- upd_pred_taken  in  1  prediction carried down the pipe with the instruction
- upd_pred_target  in  32  predicted next PC carried down the pipe
- mispredict  out  1  redirect required
- correct_pc  out  32  upd_taken ? upd_target : upd_pc+4
- inv_all  in  1  invalidate all entries
- stat_hits  out  CNT_W  lookup hits (BTB_STATS_EN only)
- stat_mispred  out  CNT_W  mispredicts (BTB_STATS_EN only)

Behaviour:
- Entry contents: valid, tag[TAG_W], target[32], cnt[2]. idx = pc[IDX_W+1:2].
- Lookup: purely combinational, same cycle. lu_hit = valid[idx] && tag match. Outputs are 0 / lu_pc+4 on a miss.
- mispredict (combinational, gated by upd_en): (upd_taken != upd_pred_taken) || (upd_taken && upd_target != upd_pred_target). Outputs 0 when upd_en=0.
- Update is registered at CLK rising edge when upd_en=1.
  - Hit at upd_pc: counter saturates toward 11 if taken, toward 00 if not taken. Target is overwritten with upd_target if taken.
  - Miss and taken: allocate, overwriting any entry at idx. Set valid=1, tag, target; cnt=11 if upd_jump, else 10.
  - Miss and not taken: no change.
  - upd_jump on a hit: cnt forced to 11.
- Same-cycle lookup and update to the same idx: lookup returns pre-update contents; the new contents are visible next cycle.
- inv_all: all valid bits cleared at the next edge. It takes priority over a simultaneous update, so the update is dropped.
- Reset (synchronous): all valid=0, cnt=01, tags/targets don't-care. From the next cycle: lu_hit=0, pred_taken=0, pred_target=lu_pc+4, mispredict=0, stats=0.
- Reset asserted mid-training discards that cycle's update.
- Arithmetic: +4 wraps modulo 2^32 (lu_pc=FFFFFFFC gives pred_target=00000000).
- JR targets are stored like any other target; a register-changed target shows up as a target-mismatch mispredict.

Optional Feature:
- Macro BTB_STATS_EN.
- Defined:
  - stat_hits increments each cycle lu_hit=1.
  - stat_mispred increments each cycle mispredict=1.
  - Both saturate at all-ones, clear on RST, and are not cleared by inv_all.
- Undefined: stat ports absent; no counter logic.

Test Plan:
- Reset then lu_pc=00000040 -> lu_hit=0, pred_taken=0, pred_target=00000044.
- upd_en, upd_pc=00000040, upd_taken=1, upd_target=00000100, upd_pred_taken=0 -> mispredict=1, correct_pc=00000100. Next cycle lu_pc=00000040 -> lu_hit=1, pred_taken=1, pred_target=00000100.
- Train the same PC not-taken twice (pred_taken=1 both times) -> cnt 10->01->00; mispredict=1 both updates; after the first update pred_taken=0, pred_target=00000044.
- Aliasing: allocate 00000040 taken, then 00000440 taken (same idx, different tag) -> lookup 00000040 gives lu_hit=0; lookup 00000440 hits.
- Same-cycle update and lookup on 00000080 (first-time allocate) -> lookup that cycle misses, hits next cycle. inv_all with update -> entry not allocated; all lookups miss.
- BTB_STATS_EN: 3 hitting lookups and 2 mispredicts -> stat_hits=3, stat_mispred=2. Then RST -> both 0.
